// File: rtl/alu_pkg.sv
// Shared definitions for the adder result stage.
//   op_t    : operation codes carried on in_op
//   flags_t : {overflow, negative, zero, cout} flag bundle
//   state_t : output register occupancy (EMPTY / FULL)
package alu_pkg;

  typedef enum logic [1:0] {
    OP_PASS         = 2'd0,
    OP_ACCUM        = 2'd1,
    OP_CLEAR        = 2'd2,
    OP_CLEAR_STICKY = 2'd3
  } op_t;

  typedef struct packed {
    logic overflow;
    logic negative;
    logic zero;
    logic cout;
  } flags_t;

  // Flags that describe a data value of zero.
  localparam flags_t FLAGS_ZERO = '{overflow: 1'b0, negative: 1'b0, zero: 1'b1, cout: 1'b0};

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/signed_adder.sv
// Two's-complement adder/subtractor with status flags.
// Ports:
//   a, b      : operands
//   add_sub   : 0 = a + b, 1 = a - b
//   s         : WIDTH-bit wrapped result
//   overflow  : signed overflow
//   negative  : s[MSB]
//   zero      : s == 0
//   cout      : carry out of the WIDTH-bit add (inverted-borrow when subtracting)
module signed_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             add_sub,
  output logic [WIDTH-1:0] s,
  output logic             overflow,
  output logic             negative,
  output logic             zero,
  output logic             cout
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   full_sum;

  // Subtraction is a + ~b + 1, so the carry-in doubles as the add_sub bit.
  assign b_eff    = add_sub ? ~b : b;
  assign full_sum = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, add_sub};

  assign s        = full_sum[WIDTH-1:0];
  assign cout     = full_sum[WIDTH];
  assign overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) & (s[WIDTH-1] != a[WIDTH-1]);
  assign negative = s[WIDTH-1];
  assign zero     = (s == '0);

endmodule

// File: rtl/alu_accumulator.sv
// Registered result stage behind signed_adder.
// Captures an adder result under valid/ready, optionally folds it into a
// running accumulator, and keeps a sticky overflow bit and an op counter.
// Ports:
//   clk, rst                : clock, asynchronous active-high reset
//   in_valid / in_ready     : upstream handshake
//   in_op                   : 0 PASS, 1 ACCUM, 2 CLEAR, 3 CLEAR_STICKY
//   in_s, in_overflow, in_negative, in_zero, in_cout : adder result and flags
//   out_valid / out_ready   : downstream handshake
//   out_data, out_overflow, out_negative, out_zero, out_cout : registered result
//   acc                     : accumulator value
//   sticky_ovf              : any overflow since last CLEAR_STICKY
//   op_count                : accepted operations, wrapping
module alu_accumulator
  import alu_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_op,
  input  logic [WIDTH-1:0]     in_s,
  input  logic                 in_overflow,
  input  logic                 in_negative,
  input  logic                 in_zero,
  input  logic                 in_cout,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_overflow,
  output logic                 out_negative,
  output logic                 out_zero,
  output logic                 out_cout,
  output logic [WIDTH-1:0]     acc,
  output logic                 sticky_ovf,
  output logic [CNT_WIDTH-1:0] op_count
);

  state_t           state;
  op_t              op;
  logic             transfer;
  logic [WIDTH-1:0] acc_sum;
  flags_t           acc_flags;
  logic [WIDTH-1:0] data_next;
  flags_t           flags_next;
  logic [WIDTH-1:0] acc_next;
  logic             sticky_next;

  assign op        = op_t'(in_op);
  assign out_valid = (state == ST_FULL);
  // A full register can still accept when the consumer drains it this cycle.
  assign in_ready  = ~out_valid | out_ready;
  assign transfer  = in_valid & in_ready;

  signed_adder #(.WIDTH(WIDTH)) u_accum_adder (
    .a        (acc),
    .b        (in_s),
    .add_sub  (1'b0),
    .s        (acc_sum),
    .overflow (acc_flags.overflow),
    .negative (acc_flags.negative),
    .zero     (acc_flags.zero),
    .cout     (acc_flags.cout)
  );

  always_comb begin
    data_next   = in_s;
    flags_next  = '{overflow: in_overflow, negative: in_negative, zero: in_zero, cout: in_cout};
    acc_next    = acc;
    sticky_next = sticky_ovf | in_overflow;
    case (op)
      OP_ACCUM: begin
        data_next   = acc_sum;
        flags_next  = acc_flags;
        acc_next    = acc_sum;
        sticky_next = sticky_ovf | acc_flags.overflow;
      end
      OP_CLEAR: begin
        data_next   = '0;
        flags_next  = FLAGS_ZERO;
        acc_next    = '0;
        sticky_next = sticky_ovf;
      end
      // Result passes through, but the incoming overflow must not re-arm the
      // sticky bit being cleared.
      OP_CLEAR_STICKY: sticky_next = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_EMPTY;
      out_data     <= '0;
      out_overflow <= FLAGS_ZERO.overflow;
      out_negative <= FLAGS_ZERO.negative;
      out_zero     <= FLAGS_ZERO.zero;
      out_cout     <= FLAGS_ZERO.cout;
      acc          <= '0;
      sticky_ovf   <= 1'b0;
      op_count     <= '0;
    end else begin
      case (state)
        ST_EMPTY: if (transfer) state <= ST_FULL;
        ST_FULL:  if (!transfer && out_ready) state <= ST_EMPTY;
        default:  state <= ST_EMPTY;
      endcase

      if (transfer) begin
        out_data     <= data_next;
        out_overflow <= flags_next.overflow;
        out_negative <= flags_next.negative;
        out_zero     <= flags_next.zero;
        out_cout     <= flags_next.cout;
        acc          <= acc_next;
        sticky_ovf   <= sticky_next;
        op_count     <= op_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_accumulator.sv
module tb_alu_accumulator;

  localparam int W  = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_op;
  logic [W-1:0]  in_s;
  logic          in_overflow, in_negative, in_zero, in_cout;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_overflow, out_negative, out_zero, out_cout;
  logic [W-1:0]  acc;
  logic          sticky_ovf;
  logic [CW-1:0] op_count;

  always #5 clk = ~clk;

  alu_accumulator #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_s         (in_s),
    .in_overflow  (in_overflow),
    .in_negative  (in_negative),
    .in_zero      (in_zero),
    .in_cout      (in_cout),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_overflow (out_overflow),
    .out_negative (out_negative),
    .out_zero     (out_zero),
    .out_cout     (out_cout),
    .acc          (acc),
    .sticky_ovf   (sticky_ovf),
    .op_count     (op_count)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state, in plain integers.
  bit m_valid;
  int m_data, m_acc, m_cnt;
  bit m_ovf, m_neg, m_zero, m_cout, m_sticky;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s differs", tag);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_data = 0; m_acc = 0; m_cnt = 0;
    m_ovf = 0; m_neg = 0; m_zero = 1; m_cout = 0; m_sticky = 0;
  endtask

  task automatic check_outputs(input string ctx);
    chk({ctx, ".out_valid"},    out_valid,    m_valid);
    chk({ctx, ".out_data"},     out_data,     m_data);
    chk({ctx, ".out_overflow"}, out_overflow, m_ovf);
    chk({ctx, ".out_negative"}, out_negative, m_neg);
    chk({ctx, ".out_zero"},     out_zero,     m_zero);
    chk({ctx, ".out_cout"},     out_cout,     m_cout);
    chk({ctx, ".acc"},          acc,          m_acc);
    chk({ctx, ".sticky_ovf"},   sticky_ovf,   m_sticky);
    chk({ctx, ".op_count"},     op_count,     m_cnt);
  endtask

  // One clock cycle of stimulus; call between edges (after a posedge).
  task automatic apply(input string ctx, input bit v, input int op, input int s,
                       input bit [3:0] fl, input bit ordy);
    bit xfer;
    int ssum, usum;
    in_valid = v; in_op = op[1:0]; in_s = s[7:0];
    {in_overflow, in_negative, in_zero, in_cout} = fl;
    out_ready = ordy;
    #1;
    xfer = v && (!m_valid || ordy);
    chk({ctx, ".in_ready"}, in_ready, (!m_valid || ordy));
    @(posedge clk);
    if (xfer) begin
      case (op)
        1: begin
          ssum   = (m_acc >= 128 ? m_acc - 256 : m_acc) + ((s & 255) >= 128 ? (s & 255) - 256 : (s & 255));
          usum   = m_acc + (s & 255);
          m_ovf  = (ssum > 127) || (ssum < -128);
          m_cout = usum > 255;
          m_data = usum % 256;
          m_neg  = m_data >= 128;
          m_zero = m_data == 0;
          m_acc  = m_data;
          m_sticky = m_sticky || m_ovf;
        end
        2: begin
          m_data = 0; m_acc = 0;
          m_ovf = 0; m_neg = 0; m_zero = 1; m_cout = 0;
        end
        default: begin
          m_data = s & 255;
          {m_ovf, m_neg, m_zero, m_cout} = fl;
          m_sticky = (op == 3) ? 1'b0 : (m_sticky || fl[3]);
        end
      endcase
      m_cnt   = (m_cnt + 1) % 256;
      m_valid = 1;
      $display("xfer %s op=%0d s=%02h -> data=%02h acc=%02h cnt=%0d", ctx, op, s & 255, m_data, m_acc, m_cnt);
    end else if (ordy) begin
      m_valid = 0;
    end
    #1;
    check_outputs(ctx);
  endtask

  initial begin
    int cnt_before;
    rst = 1; in_valid = 0; in_op = 0; in_s = 0;
    {in_overflow, in_negative, in_zero, in_cout} = 4'b0;
    out_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    chk("reset.in_ready", in_ready, 1'b1);
    @(negedge clk) rst = 0;
    @(posedge clk); #1;

    // Simple pass-through.
    apply("pass05", 1, 0, 8'h05, 4'b0000, 1);
    chk("pass05.zero", out_zero, 1'b0);

    // Signed overflow through accumulation.
    apply("accum70", 1, 1, 8'h70, 4'b0000, 1);
    apply("accum20", 1, 1, 8'h20, 4'b0000, 1);
    chk("accum20.acc_const", acc, 8'h90);
    chk("accum20.ovf_const", out_overflow, 1'b1);

    // Backpressure: result must freeze, then drain exactly once.
    apply("hold_load", 1, 0, $urandom_range(0, 255), 4'($urandom), 1);
    for (int i = 0; i < 5; i++)
      apply("hold", 1, 0, $urandom_range(0, 255), 4'($urandom), 0);
    apply("release", 1, 1, $urandom_range(0, 255), 4'($urandom), 1);

    // Back-to-back throughput.
    cnt_before = m_cnt;
    for (int i = 0; i < 10; i++)
      apply("b2b", 1, $urandom_range(0, 3), $urandom_range(0, 255), 4'($urandom), 1);
    chk("b2b.count", op_count, 8'((cnt_before + 10) % 256));

    // Clears: set sticky, load acc=0x33, CLEAR, then CLEAR_STICKY.
    apply("set_sticky", 1, 0, 8'h11, 4'b1000, 1);
    apply("clr0", 1, 2, 8'h00, 4'b0000, 1);
    apply("load33", 1, 1, 8'h33, 4'b0000, 1);
    chk("load33.acc_const", acc, 8'h33);
    apply("clear", 1, 2, 8'h7f, 4'b1111, 1);
    chk("clear.sticky_const", sticky_ovf, 1'b1);
    apply("clear_sticky", 1, 3, 8'h80, 4'b1100, 1);
    chk("clear_sticky.const", sticky_ovf, 1'b0);

    // Random traffic with random handshakes.
    for (int i = 0; i < 150; i++)
      apply("rand", 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 255),
            4'($urandom), 1'($urandom));

    // Asynchronous reset while holding a valid result.
    apply("pre_rst", 1, 0, 8'hA5, 4'b0100, 0);
    in_valid = 0;
    #1 rst = 1;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(negedge clk) rst = 0;
    @(posedge clk); #1;

    // Counter wrap after exactly 256 transfers.
    for (int i = 0; i < 256; i++)
      apply("wrap", 1, $urandom_range(0, 3), $urandom_range(0, 255), 4'($urandom), 1);
    chk("wrap.op_count_const", op_count, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
